// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue front end.
package alu_pkg;

   localparam int unsigned DATA_W = 2;
   localparam int unsigned NREGS  = 4;
   localparam int unsigned ADDR_W = $clog2(NREGS);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Preload, command, ALU-side and writeback signals of the issue controller.
interface alu_issue_ctrl_if;

   logic                         ld_en;
   logic [alu_pkg::ADDR_W-1:0]   ld_addr;
   logic [alu_pkg::DATA_W-1:0]   ld_data;

   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [1:0]                   cmd_op;
   logic [alu_pkg::ADDR_W-1:0]   cmd_rs1;
   logic [alu_pkg::ADDR_W-1:0]   cmd_rs2;
   logic [alu_pkg::ADDR_W-1:0]   cmd_rd;

   logic [alu_pkg::DATA_W-1:0]   alu_a;
   logic [alu_pkg::DATA_W-1:0]   alu_b;
   logic [1:0]                   alu_sel;
   logic [alu_pkg::DATA_W-1:0]   alu_result;
   logic                         alu_carry;

   logic                         wb_valid;
   logic                         wb_ready;
   logic [alu_pkg::ADDR_W-1:0]   wb_rd;
   logic [alu_pkg::DATA_W-1:0]   wb_data;
   logic                         wb_carry;
   logic                         flag_c;

   // Issue controller side.
   modport slave (
      input  ld_en, ld_addr, ld_data,
      input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
      output cmd_ready,
      output alu_a, alu_b, alu_sel,
      input  alu_result, alu_carry,
      output wb_valid, wb_rd, wb_data, wb_carry, flag_c,
      input  wb_ready
   );

   // Command source / ALU / writeback consumer side.
   modport master (
      output ld_en, ld_addr, ld_data,
      output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
      input  cmd_ready,
      input  alu_a, alu_b, alu_sel,
      output alu_result, alu_carry,
      input  wb_valid, wb_rd, wb_data, wb_carry, flag_c,
      output wb_ready
   );

endinterface

// File: rtl/alu_regfile.sv
// Operand register file: two async read ports, one sync write port, async clear.
module alu_regfile #(
   parameter int unsigned NREGS  = 4,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] mem [NREGS];

   // Storage with clear on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front end for the 2-bit ALU: operand fetch, result capture, writeback.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   alu_issue_ctrl_if.slave  bus
);

   state_t              state;
   logic [ADDR_W-1:0]   rd_q;
   logic [DATA_W-1:0]   alu_a_q;
   logic [DATA_W-1:0]   alu_b_q;
   logic [1:0]          alu_sel_q;
   logic                wb_valid_q;
   logic [ADDR_W-1:0]   wb_rd_q;
   logic [DATA_W-1:0]   wb_data_q;
   logic                wb_carry_q;
   logic                flag_c_q;

   logic                rf_we;
   logic [ADDR_W-1:0]   rf_waddr;
   logic [DATA_W-1:0]   rf_wdata;
   logic [DATA_W-1:0]   rf_rdata1;
   logic [DATA_W-1:0]   rf_rdata2;
   logic                cmd_fire;

   // A preload in the same cycle blocks the command, so the load wins.
   assign bus.cmd_ready = (state == IDLE) && !bus.ld_en;
   assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

   // Write port shared by the preload path (IDLE) and the result path (EXEC).
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = bus.ld_addr;
      rf_wdata = bus.ld_data;
      if (state == IDLE && bus.ld_en) begin
         rf_we = 1'b1;
      end else if (state == EXEC) begin
         rf_we    = 1'b1;
         rf_waddr = rd_q;
         rf_wdata = bus.alu_result;
      end
   end

   alu_regfile #(
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (bus.cmd_rs1),
      .raddr2 (bus.cmd_rs2),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   // Issue FSM with registered ALU operands and writeback record.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rd_q       <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_carry_q <= 1'b0;
         flag_c_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  alu_a_q   <= rf_rdata1;
                  alu_b_q   <= rf_rdata2;
                  alu_sel_q <= bus.cmd_op;
                  rd_q      <= bus.cmd_rd;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               wb_data_q  <= bus.alu_result;
               wb_carry_q <= bus.alu_carry;
               flag_c_q   <= bus.alu_carry;
               wb_rd_q    <= rd_q;
               wb_valid_q <= 1'b1;
               state      <= WB;
            end
            WB: begin
               if (bus.wb_ready) begin
                  wb_valid_q <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.alu_sel  = alu_sel_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_rd    = wb_rd_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_carry = wb_carry_q;
   assign bus.flag_c   = flag_c_q;

endmodule
